// File: rtl/multi_cycle_ctrl_pkg.sv
// rtl/multi_cycle_ctrl_pkg.sv - shared encodings for the multi-cycle controller
package multi_cycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ORI  = 6'h0D, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08, FN_ADD  = 6'h20, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25, FN_SLT  = 6'h2A;

  localparam int ALUOP_DW = 5;
  localparam logic [ALUOP_DW-1:0] ALUOP_ADD  = 5'd0, ALUOP_ADDU = 5'd1, ALUOP_SUB = 5'd2;
  localparam logic [ALUOP_DW-1:0] ALUOP_SUBU = 5'd3, ALUOP_AND  = 5'd4, ALUOP_OR  = 5'd5;
  localparam logic [ALUOP_DW-1:0] ALUOP_SLT  = 5'd6, ALUOP_SLL  = 5'd7, ALUOP_SRL = 5'd8;
  localparam logic [ALUOP_DW-1:0] ALUOP_SRA  = 5'd9, ALUOP_LUI  = 5'd10;

  localparam logic [1:0] NPC_PLUS4 = 2'd0, NPC_BRANCH = 2'd1, NPC_JUMP = 2'd2, NPC_JR = 2'd3;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_HIGH = 2'd2;
  localparam logic [1:0] REGDST_RD = 2'd0, REGDST_RT = 2'd1, REGDST_R31 = 2'd2;
  localparam logic [1:0] M2R_ALU = 2'd0, M2R_MEM = 2'd1, M2R_PC4 = 2'd2;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR
  } iclass_e;

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// rtl/multi_cycle_ctrl_decode.sv - combinational op/funct decode table
module instr_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  output logic                legal,
  output iclass_e             iclass,
  output logic [ALUOP_DW-1:0] aluop,
  output logic                alusrc,
  output logic [1:0]          extop
);

  always_comb begin
    legal  = 1'b1;
    iclass = CL_R;
    aluop  = ALUOP_ADDU;
    alusrc = 1'b0;
    extop  = EXT_ZERO;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  aluop = ALUOP_ADD;
          FN_ADDU: aluop = ALUOP_ADDU;
          FN_SUB:  aluop = ALUOP_SUB;
          FN_SUBU: aluop = ALUOP_SUBU;
          FN_AND:  aluop = ALUOP_AND;
          FN_OR:   aluop = ALUOP_OR;
          FN_SLT:  aluop = ALUOP_SLT;
          FN_SLL:  aluop = ALUOP_SLL;
          FN_SRL:  aluop = ALUOP_SRL;
          FN_SRA:  aluop = ALUOP_SRA;
          FN_JR:   iclass = CL_JR;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin iclass = CL_I;  aluop = ALUOP_ADD;  alusrc = 1'b1; extop = EXT_SIGN; end
      OP_SLTI: begin iclass = CL_I;  aluop = ALUOP_SLT;  alusrc = 1'b1; extop = EXT_SIGN; end
      OP_ORI:  begin iclass = CL_I;  aluop = ALUOP_OR;   alusrc = 1'b1; end
      OP_LUI:  begin iclass = CL_I;  aluop = ALUOP_LUI;  alusrc = 1'b1; extop = EXT_HIGH; end
      OP_LW:   begin iclass = CL_LW; alusrc = 1'b1; extop = EXT_SIGN; end
      OP_SW:   begin iclass = CL_SW; alusrc = 1'b1; extop = EXT_SIGN; end
      // Branch compare is a subtract; the sign-extended offset feeds the target adder.
      OP_BEQ:  begin iclass = CL_BEQ; aluop = ALUOP_SUBU; extop = EXT_SIGN; end
      OP_BNE:  begin iclass = CL_BNE; aluop = ALUOP_SUBU; extop = EXT_SIGN; end
      OP_J:    iclass = CL_J;
      OP_JAL:  iclass = CL_JAL;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS-subset control FSM with memory wait timeout
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               mem_ready,
  input  logic               alu_zero,
  output logic               PCWr,
  output logic [1:0]         PCSrc,
  output logic               IRWr,
  output logic               MemR,
  output logic               MemW,
  output logic               RegW,
  output logic [1:0]         RegDst,
  output logic [1:0]         Mem2R,
  output logic               Alusrc,
  output logic [1:0]         EXTOp,
  output logic [ALUOP_W-1:0] Aluctrl,
  output logic [2:0]         state_o,
  output logic               halt,
  output logic               illegal,
  output logic               bus_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e              state, next;
  logic [5:0]          op_q, fn_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic                latch, set_ill, set_be, mem_to;
  logic                dec_legal, dec_alusrc;
  iclass_e             dec_class;
  logic [ALUOP_DW-1:0] dec_aluop, aluop;
  logic [1:0]          dec_extop;

  instr_decode u_decode (
    .op     (op_q),
    .funct  (fn_q),
    .legal  (dec_legal),
    .iclass (dec_class),
    .aluop  (dec_aluop),
    .alusrc (dec_alusrc),
    .extop  (dec_extop)
  );

  // Fires on the TIMEOUT-th consecutive wait cycle; a same-cycle mem_ready takes priority.
  assign mem_to  = (TIMEOUT > 0) && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign Aluctrl = ALUOP_W'(aluop);
  assign state_o = state;
  assign halt    = (state == S_HALT);

  always_comb begin
    next    = state;
    PCWr    = 1'b0;
    PCSrc   = NPC_PLUS4;
    IRWr    = 1'b0;
    MemR    = 1'b0;
    MemW    = 1'b0;
    RegW    = 1'b0;
    RegDst  = REGDST_RD;
    Mem2R   = M2R_ALU;
    Alusrc  = 1'b0;
    EXTOp   = EXT_ZERO;
    aluop   = '0;
    latch   = 1'b0;
    set_ill = 1'b0;
    set_be  = 1'b0;
    case (state)
      S_IF: begin
        MemR = 1'b1;
        if (mem_ready) begin
          IRWr  = 1'b1;
          PCWr  = 1'b1;
          latch = 1'b1;
          next  = S_ID;
        end else if (mem_to) begin
          set_be = 1'b1;
          next   = S_HALT;
        end
      end
      S_ID: begin
        if (!dec_legal) begin
          set_ill = 1'b1;
          next    = S_HALT;
        end else if (dec_class == CL_J || dec_class == CL_JAL) begin
          PCWr  = 1'b1;
          PCSrc = NPC_JUMP;
          next  = S_IF;
          if (dec_class == CL_JAL) begin
            RegW   = 1'b1;
            RegDst = REGDST_R31;
            Mem2R  = M2R_PC4;
          end
        end else begin
          next = S_EX;
        end
      end
      S_EX: begin
        aluop  = dec_aluop;
        Alusrc = dec_alusrc;
        EXTOp  = dec_extop;
        case (dec_class)
          CL_BEQ:        begin PCWr = alu_zero;  PCSrc = NPC_BRANCH; next = S_IF; end
          CL_BNE:        begin PCWr = !alu_zero; PCSrc = NPC_BRANCH; next = S_IF; end
          CL_JR:         begin PCWr = 1'b1;      PCSrc = NPC_JR;     next = S_IF; end
          CL_LW, CL_SW:  next = S_MEM;
          default:       next = S_WB;
        endcase
      end
      S_MEM: begin
        Alusrc = 1'b1;
        EXTOp  = EXT_SIGN;
        aluop  = ALUOP_ADDU;
        MemR   = (dec_class == CL_LW);
        MemW   = (dec_class == CL_SW);
        if (mem_ready) begin
          next = (dec_class == CL_LW) ? S_WB : S_IF;
        end else if (mem_to) begin
          set_be = 1'b1;
          next   = S_HALT;
        end
      end
      S_WB: begin
        RegW   = 1'b1;
        RegDst = (dec_class == CL_R) ? REGDST_RD : REGDST_RT;
        Mem2R  = (dec_class == CL_LW) ? M2R_MEM : M2R_ALU;
        next   = S_IF;
      end
      S_HALT: next = S_HALT;
      default: next = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IF;
      op_q     <= '0;
      fn_q     <= '0;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state <= next;
      if (latch) begin
        op_q <= OpCode;
        fn_q <= Funct;
      end
      if (next != state)
        wait_cnt <= '0;
      else if ((state == S_IF || state == S_MEM) && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (set_ill) illegal <= 1'b1;
      if (set_be)  bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - randomized self-checking bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

  localparam int TO = 4;
  localparam int NI = 21;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5;
  localparam int K_J = 6, K_JAL = 7, K_JR = 8;

  logic       clk = 1'b0, rst = 1'b1, mem_ready = 1'b0, alu_zero = 1'b0;
  logic [5:0] OpCode = '0, Funct = '0;
  logic       PCWr, IRWr, MemR, MemW, RegW, Alusrc, halt, illegal, bus_err;
  logic [1:0] PCSrc, RegDst, Mem2R, EXTOp;
  logic [4:0] Aluctrl;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.ALUOP_W(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .MemR(MemR),
    .MemW(MemW), .RegW(RegW), .RegDst(RegDst), .Mem2R(Mem2R), .Alusrc(Alusrc),
    .EXTOp(EXTOp), .Aluctrl(Aluctrl), .state_o(state_o), .halt(halt),
    .illegal(illegal), .bus_err(bus_err)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pcwr;
    logic [1:0] pcsrc;
    logic       irwr, memr, memw, regw;
    logic [1:0] regdst, m2r;
    logic       alusrc;
    logic [1:0] ext;
    logic [4:0] alu;
    logic       hlt, ill, be;
  } out_t;

  typedef struct {
    bit         r, c;
    logic       rdy, z;
    logic [5:0] op, fn;
    out_t       e;
  } step_t;

  typedef struct {
    string      nm;
    logic [5:0] op, fn;
    int         kind;
    logic [4:0] alu;
    logic       src;
    logic [1:0] ext;
  } ins_t;

  ins_t  tbl [NI];
  step_t q[$];
  string tags[$];
  int    checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic def(input int i, input string n, input int op, input int fn, input int kind,
                     input int alu, input int src, input int ext);
    tbl[i].nm = n; tbl[i].op = 6'(op); tbl[i].fn = 6'(fn); tbl[i].kind = kind;
    tbl[i].alu = 5'(alu); tbl[i].src = 1'(src); tbl[i].ext = 2'(ext);
  endtask

  function automatic out_t observed();
    out_t o;
    o = '{state_o, PCWr, PCSrc, IRWr, MemR, MemW, RegW, RegDst, Mem2R, Alusrc, EXTOp,
          Aluctrl, halt, illegal, bus_err};
    return o;
  endfunction

  task automatic push(input bit r, input bit c, input logic rdy, input logic z,
                      input logic [5:0] op, input logic [5:0] fn, input out_t e, input string tag);
    step_t s;
    s.r = r; s.c = c; s.rdy = rdy; s.z = z; s.op = op; s.fn = fn; s.e = e;
    q.push_back(s);
    tags.push_back(tag);
  endtask

  // Opcode/funct/alu_zero are noise outside the cycles where they matter.
  task automatic push_idle(input out_t e, input string tag, input logic rdy);
    push(1'b0, 1'b1, rdy, 1'($urandom), 6'($urandom), 6'($urandom), e, tag);
  endtask

  task automatic push_rst();
    push(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, "rst");
  endtask

  task automatic add_halt(input logic ill, input logic be, input int n);
    out_t e = '0;
    e.st = 3'd5; e.hlt = 1'b1; e.ill = ill; e.be = be;
    repeat (n) push_idle(e, ill ? "halt_illegal" : "halt_bus_err", 1'($urandom));
    push_rst();
  endtask

  task automatic add_illegal(input logic [5:0] op, input logic [5:0] fn);
    out_t e = '0;
    e.memr = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
    push(1'b0, 1'b1, 1'b1, 1'b0, op, fn, e, "illegal/if");
    e = '0; e.st = 3'd1;
    push_idle(e, "illegal/id", 1'($urandom));
    add_halt(1'b1, 1'b0, 20);
  endtask

  // wi/wm: wait states in fetch/memory (>= TO means the access never completes).
  // rst_at: 1 = reset after the fetch waits, 2 = reset after the memory waits.
  task automatic add_instr(input int i, input int wi, input int wm, input logic z, input int rst_at);
    ins_t       t = tbl[i];
    out_t       e;
    logic [5:0] fn;
    bool_wb: begin end
    fn = (t.kind == K_R || t.kind == K_JR) ? t.fn : 6'($urandom);
    for (int k = 0; k < wi && k < TO; k++) begin
      e = '0; e.memr = 1'b1;
      push_idle(e, {t.nm, "/if_wait"}, 1'b0);
    end
    if (rst_at == 1) begin push_rst(); return; end
    if (wi >= TO) begin add_halt(1'b0, 1'b1, 3); return; end
    e = '0; e.memr = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
    push(1'b0, 1'b1, 1'b1, 1'($urandom), t.op, fn, e, {t.nm, "/if"});
    e = '0; e.st = 3'd1;
    if (t.kind == K_J || t.kind == K_JAL) begin
      e.pcwr = 1'b1; e.pcsrc = 2'd2;
      if (t.kind == K_JAL) begin e.regw = 1'b1; e.regdst = 2'd2; e.m2r = 2'd2; end
    end
    push_idle(e, {t.nm, "/id"}, 1'($urandom));
    if (t.kind == K_J || t.kind == K_JAL) return;
    e = '0; e.st = 3'd2; e.alu = t.alu; e.alusrc = t.src; e.ext = t.ext;
    if (t.kind == K_BEQ) begin e.pcwr = z;  e.pcsrc = 2'd1; end
    if (t.kind == K_BNE) begin e.pcwr = !z; e.pcsrc = 2'd1; end
    if (t.kind == K_JR)  begin e.pcwr = 1'b1; e.pcsrc = 2'd3; end
    push(1'b0, 1'b1, 1'($urandom), z, 6'($urandom), 6'($urandom), e, {t.nm, "/ex"});
    if (t.kind == K_LW || t.kind == K_SW) begin
      e = '0; e.st = 3'd3; e.alusrc = 1'b1; e.ext = 2'd1; e.alu = 5'd1;
      e.memr = (t.kind == K_LW); e.memw = (t.kind == K_SW);
      for (int k = 0; k < wm && k < TO; k++) push_idle(e, {t.nm, "/mem_wait"}, 1'b0);
      if (rst_at == 2) begin push_rst(); return; end
      if (wm >= TO) begin add_halt(1'b0, 1'b1, 3); return; end
      push_idle(e, {t.nm, "/mem"}, 1'b1);
      if (t.kind == K_SW) return;
    end
    if (t.kind == K_R || t.kind == K_I || t.kind == K_LW) begin
      e = '0; e.st = 3'd4; e.regw = 1'b1;
      e.regdst = (t.kind == K_R) ? 2'd0 : 2'd1;
      e.m2r    = (t.kind == K_LW) ? 2'd1 : 2'd0;
      push_idle(e, {t.nm, "/wb"}, 1'($urandom));
    end
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 15) == 0) ? TO : int'($urandom_range(0, TO - 1));
  endfunction

  initial begin
    def(0, "addu", 6'h00, 6'h21, K_R, 1, 0, 0);   def(1, "add", 6'h00, 6'h20, K_R, 0, 0, 0);
    def(2, "sub", 6'h00, 6'h22, K_R, 2, 0, 0);    def(3, "subu", 6'h00, 6'h23, K_R, 3, 0, 0);
    def(4, "and", 6'h00, 6'h24, K_R, 4, 0, 0);    def(5, "or", 6'h00, 6'h25, K_R, 5, 0, 0);
    def(6, "slt", 6'h00, 6'h2A, K_R, 6, 0, 0);    def(7, "sll", 6'h00, 6'h00, K_R, 7, 0, 0);
    def(8, "srl", 6'h00, 6'h02, K_R, 8, 0, 0);    def(9, "sra", 6'h00, 6'h03, K_R, 9, 0, 0);
    def(10, "jr", 6'h00, 6'h08, K_JR, 1, 0, 0);   def(11, "addi", 6'h08, 0, K_I, 0, 1, 1);
    def(12, "slti", 6'h0A, 0, K_I, 6, 1, 1);      def(13, "ori", 6'h0D, 0, K_I, 5, 1, 0);
    def(14, "lui", 6'h0F, 0, K_I, 10, 1, 2);      def(15, "lw", 6'h23, 0, K_LW, 1, 1, 1);
    def(16, "sw", 6'h2B, 0, K_SW, 1, 1, 1);       def(17, "beq", 6'h04, 0, K_BEQ, 3, 0, 1);
    def(18, "bne", 6'h05, 0, K_BNE, 3, 0, 1);     def(19, "j", 6'h02, 0, K_J, 0, 0, 0);
    def(20, "jal", 6'h03, 0, K_JAL, 0, 0, 0);

    push_rst(); push_rst();
    add_instr(0, 0, 0, 1'b0, 0);           // addu, no waits
    add_instr(15, 3, 2, 1'b0, 0);          // lw, 3 fetch + 2 memory waits
    add_instr(17, 0, 0, 1'b1, 0);          // beq taken
    add_instr(17, 0, 0, 1'b0, 0);          // beq not taken
    add_instr(20, 0, 0, 1'b0, 0);          // jal
    add_instr(16, TO - 1, TO - 1, 1'b0, 0); // ready on the last allowed wait cycle
    add_illegal(6'h3F, 6'h00);
    add_illegal(6'h00, 6'h26);
    add_instr(0, TO, 0, 1'b0, 0);          // fetch timeout
    add_instr(1, 2, 0, 1'b0, 1);           // reset mid-fetch wait
    add_instr(0, TO, 0, 1'b0, 0);          // counter restarted from 0
    add_instr(15, 0, 2, 1'b0, 2);          // reset mid-memory wait
    add_instr(16, 0, TO, 1'b0, 0);         // memory timeout
    for (int n = 0; n < 120; n++)
      add_instr(int'($urandom_range(0, NI - 1)), rand_wait(), rand_wait(), 1'($urandom), 0);

    @(negedge clk);
    foreach (q[i]) begin
      rst = q[i].r; mem_ready = q[i].rdy; alu_zero = q[i].z;
      OpCode = q[i].op; Funct = q[i].fn;
      #1;
      if (q[i].c) check(tags[i], 32'(observed()), 32'(q[i].e));
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter ALUOP_W, default 5, Aluctrl width.
REQ-002 SHALL have parameter TIMEOUT, default 16, max wait cycles per memory access; 0 disables the timeout.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 OpCode  in  6  instr[31:26] from memory read data, valid when mem_ready=1 in S_IF.
REQ-006 Funct  in  6  instr[5:0], same validity as OpCode.
REQ-007 mem_ready  in  1  memory handshake: current MemR/MemW access completes this cycle.
REQ-008 alu_zero  in  1  ALU zero flag, valid in S_EX.
REQ-009 PCWr  out  1  PC write enable.
REQ-010 PCSrc  out  2  0 PLUS4, 1 BRANCH, 2 JUMP, 3 JR.
REQ-011 IRWr  out  1  instruction register write enable.
REQ-012 MemR, MemW  out  1 each  memory read/write request, held until mem_ready.
REQ-013 RegW  out  1  register file write enable.
REQ-014 RegDst  out  2  0 rd, 1 rt, 2 r31.
REQ-015 Mem2R  out  2  write-back select: 0 ALU, 1 memory, 2 PC+4.
REQ-016 Alusrc  out  1  0 rt, 1 extended immediate.
REQ-017 EXTOp  out  2  0 zero, 1 signed, 2 high (lui).
REQ-018 Aluctrl  out  ALUOP_W  ALU operation code.
REQ-019 state_o  out  3  current state encoding.
REQ-020 halt, illegal, bus_err  out  1 each  halted; cause = unknown opcode/funct or memory timeout.

Function
REQ-021 States SHALL be S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT.
REQ-022 Outputs SHALL be combinational from state and the latched op/funct only; each output not asserted by a state SHALL be 0.
REQ-023 S_IF: MemR=1; if mem_ready, then IRWr=1, PCWr=1, PCSrc=PLUS4, latch OpCode/Funct, go to S_ID; else stay.
REQ-024 S_ID: if op/funct is not in {add,addu,sub,subu,sll,srl,sra,jr,slt,and,or,ori,lw,sw,beq,bne,lui,j,jal,slti,addi}, go to S_HALT and set illegal.
REQ-025 S_ID, j: PCWr=1, PCSrc=JUMP, go to S_IF.
REQ-026 S_ID, jal: PCWr=1, PCSrc=JUMP, RegW=1, RegDst=2, Mem2R=2, go to S_IF.
REQ-027 S_ID, all other legal instructions: go to S_EX.
REQ-028 S_EX: Aluctrl, Alusrc and EXTOp SHALL be set per the instruction's decode table (package).
REQ-029 S_EX, beq: PCWr=alu_zero, PCSrc=BRANCH, go to S_IF.
REQ-030 S_EX, bne: PCWr=~alu_zero, PCSrc=BRANCH, go to S_IF.
REQ-031 S_EX, jr: PCWr=1, PCSrc=JR, go to S_IF.
REQ-032 S_EX: lw/sw go to S_MEM; all others go to S_WB.
REQ-033 S_MEM: Alusrc=1, EXTOp=1, Aluctrl=ADDU held; lw asserts MemR, sw asserts MemW.
REQ-034 S_MEM exit on mem_ready: lw to S_WB, sw to S_IF; else stay.
REQ-035 S_WB: RegW=1, then go to S_IF.
REQ-036 S_WB, lw: Mem2R=1, RegDst=1.
REQ-037 S_WB, I-type: Mem2R=0, RegDst=1.
REQ-038 S_WB, R-type: Mem2R=0, RegDst=0.
REQ-039 Wait counter SHALL clear on entry to S_IF/S_MEM and increment each cycle without mem_ready.
REQ-040 If TIMEOUT>0 and the counter reaches TIMEOUT, go to S_HALT with bus_err=1.
REQ-041 mem_ready and timeout in the same cycle: mem_ready wins.
REQ-042 S_HALT SHALL be absorbing until rst; halt=1 there, all control outputs 0.
REQ-043 Latency: j/jal 2 cycles, branch/jr 3, R/I ALU 4, sw 4, lw 5, each with zero wait states; each wait state adds 1.

Reset
REQ-044 rst SHALL take effect at the next clock edge from any state, including mid-memory-wait.
REQ-045 On reset: state S_IF, counter 0, latched op/funct 0, illegal=0, bus_err=0, halt=0.
REQ-046 In the first cycle after reset, outputs SHALL be S_IF values: MemR=1, all else 0.

Structure
REQ-047 Shared package SHALL hold opcode/funct constants, ALUOp_* codes, NPC_*/EXT_*/RegDst/Mem2R encodings and the state enum.
REQ-048 Decode table SHALL be a sub-module instr_decode: combinational op/funct -> {legal, class, Aluctrl, Alusrc, EXTOp}.

Verification
REQ-049 addu $3,$1,$2 with mem_ready always 1 -> states IF,ID,EX,WB,IF; RegW=1 only in WB; RegDst=0.
REQ-050 lw with 3 wait states in IF and 2 in MEM -> 10 cycles total; MemR held throughout; IRWr is a single pulse.
REQ-051 beq with alu_zero=1 -> PCWr=1, PCSrc=1 in EX; repeat with alu_zero=0 -> PCWr=0.
REQ-052 jal -> in ID: PCWr=1, PCSrc=2, RegW=1, RegDst=2, Mem2R=2; next state IF.
REQ-053 OpCode=6'h3F -> S_HALT, illegal=1; remains halted 20 cycles; rst -> S_IF.
REQ-054 TIMEOUT=4, mem_ready=0 in S_IF -> bus_err=1 after 4 cycles; rst asserted mid-wait -> counter 0, S_IF.
